// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 padder and hash core
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    WR_MSG,
    WR_PAD,
    DONE
  } padder_state_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  // 512-bit blocks needed for n words plus the 0x80 marker word and 64-bit length
  function automatic int num_blocks(input int n);
    return (n + 2) / 16 + 1;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - copies a raw message to a destination region and appends SHA-256 padding
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] input_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] memory_read_data,
  output logic        done,
  output logic        memory_clk,
  output logic        enable_write,
  output logic [15:0] memory_addr,
  output logic [31:0] memory_write_data
);

  localparam int          TOTAL  = 16 * num_blocks(NUM_OF_WORDS);
  localparam logic [31:0] LEN    = 32'(NUM_OF_WORDS * 32);
  localparam logic [15:0] N16    = 16'(NUM_OF_WORDS);
  localparam logic [15:0] T_LAST = 16'(TOTAL - 1);

  padder_state_t state;
  logic [15:0]   in_base;
  logic [15:0]   out_base;
  logic [15:0]   i;
  logic [15:0]   j;
  logic [15:0]   j_nxt;
  logic [31:0]   pad_nxt;

  assign memory_clk = clk;

  // Marker word is emitted on WR_PAD entry, so later pad slots are only zero or length
  always_comb begin
    j_nxt   = j + 16'd1;
    pad_nxt = (j_nxt == T_LAST) ? LEN : 32'd0;
  end

  // Outputs are loaded on the edge entering each state so memory sees them for that whole cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      done              <= 1'b0;
      enable_write      <= 1'b0;
      memory_addr       <= 16'd0;
      memory_write_data <= 32'd0;
      in_base           <= 16'd0;
      out_base          <= 16'd0;
      i                 <= 16'd0;
      j                 <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          enable_write <= 1'b0;
          done         <= 1'b0;
          if (start) begin
            in_base     <= input_addr;
            out_base    <= output_addr;
            i           <= 16'd0;
            memory_addr <= input_addr;
            state       <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          memory_addr       <= out_base + i;
          memory_write_data <= memory_read_data;
          enable_write      <= 1'b1;
          state             <= WR_MSG;
        end
        WR_MSG: begin
          i <= i + 16'd1;
          if (i + 16'd1 == N16) begin
            j                 <= N16;
            memory_addr       <= out_base + N16;
            memory_write_data <= PAD_WORD;
            enable_write      <= 1'b1;
            state             <= WR_PAD;
          end else begin
            memory_addr  <= in_base + i + 16'd1;
            enable_write <= 1'b0;
            state        <= RD_ADDR;
          end
        end
        WR_PAD: begin
          if (j == T_LAST) begin
            enable_write <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            j                 <= j_nxt;
            memory_addr       <= out_base + j_nxt;
            memory_write_data <= pad_nxt;
          end
        end
        DONE: begin
          done         <= 1'b0;
          enable_write <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized model-based bench for sha256_msg_padder at N=20, 13 and 14
module tb_sha256_msg_padder;

  logic        clk;
  logic        rst   [3];
  logic        start [3];
  logic        done  [3];
  logic        mclk  [3];
  logic        we    [3];
  logic [15:0] ia    [3];
  logic [15:0] oa    [3];
  logic [15:0] addr  [3];
  logic [31:0] rdata [3];
  logic [31:0] wd    [3];

  logic [31:0] mem [3][65536];
  logic        bd_we;
  int          bd_g;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;

  int n_checks = 0;
  int n_fails  = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int N_G = (gi == 0) ? 20 : (gi == 1) ? 13 : 14;
      sha256_msg_padder #(.NUM_OF_WORDS(N_G)) u_dut (
        .clk              (clk),
        .rst              (rst[gi]),
        .start            (start[gi]),
        .input_addr       (ia[gi]),
        .output_addr      (oa[gi]),
        .memory_read_data (rdata[gi]),
        .done             (done[gi]),
        .memory_clk       (mclk[gi]),
        .enable_write     (we[gi]),
        .memory_addr      (addr[gi]),
        .memory_write_data(wd[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memories with a registered read port, plus a bench preload path
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (we[g]) mem[g][addr[g]] <= wd[g];
      rdata[g] <= mem[g][addr[g]];
    end
    if (bd_we) mem[bd_g][bd_addr] <= bd_data;
  end

  function automatic int n_of(input int g);
    return (g == 0) ? 20 : (g == 1) ? 13 : 14;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int g, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_g = g; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic run(input int g, input logic [15:0] in_a, input logic [15:0] out_a,
                     input bit repulse, input int rst_cyc);
    int          n, total, exp_done, cyc, done_cnt, done_at;
    logic [31:0] src [$];
    logic [31:0] model [int];
    logic [15:0] a;
    logic [31:0] w;
    int          offs [4];
    n        = n_of(g);
    total    = 16 * ((n + 2) / 16 + 1);
    exp_done = 3 * n + (total - n) + 1;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      src.push_back(w);
      a = in_a + 16'(k);
      bd_write(g, a, w);
      model[int'(a)] = w;
    end
    offs = '{-2, -1, total, total + 1};
    foreach (offs[s]) begin
      a = out_a + 16'(offs[s]);
      w = $urandom;
      bd_write(g, a, w);
      model[int'(a)] = w;
    end
    for (int k = 0; k < total; k++) begin
      a = out_a + 16'(k);
      if (k < n)               model[int'(a)] = src[k];
      else if (k == n)         model[int'(a)] = 32'h8000_0000;
      else if (k == total - 1) model[int'(a)] = 32'(n * 32);
      else                     model[int'(a)] = 32'h0;
    end

    @(negedge clk);
    start[g] = 1'b1; ia[g] = in_a; oa[g] = out_a;
    @(posedge clk);
    #1 start[g] = 1'b0; ia[g] = 16'($urandom); oa[g] = 16'($urandom);
    cyc = 1; done_cnt = 0; done_at = 0;
    while (cyc <= exp_done + 3) begin
      @(negedge clk);
      if (done[g]) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (repulse && cyc == 3) begin
        start[g] = 1'b1; ia[g] = out_a; oa[g] = in_a + 16'h0100;
      end
      if (repulse && cyc == 4) start[g] = 1'b0;
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        check_eq("we_pre_rst", 32'(we[g]), 32'd1);
        rst[g] = 1'b1;
        #1 check_eq("we_async_rst", 32'(we[g]), 32'd0);
      end
      if (rst_cyc != 0 && cyc == rst_cyc + 1) rst[g] = 1'b0;
      @(posedge clk);
      cyc++;
    end

    if (rst_cyc == 0) begin
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("done_cycle", 32'(done_at), 32'(exp_done));
      foreach (model[k]) check_eq($sformatf("mem[%04h]", k), mem[g][k], model[k]);
    end else begin
      check_eq("done_after_rst", 32'(done_cnt), 32'd0);
      check_eq("kept_word0", mem[g][out_a], src[0]);
      check_eq("kept_word1", mem[g][out_a + 16'd1], src[1]);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          rg;
    void'($urandom(32'h0123_4675));
    bd_we = 1'b0; bd_g = 0; bd_addr = 16'd0; bd_data = 32'd0;
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; ia[g] = 16'd0; oa[g] = 16'd0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_eq("rst_done", 32'(done[g]), 32'd0);
      check_eq("rst_we", 32'(we[g]), 32'd0);
      check_eq("rst_addr", 32'(addr[g]), 32'd0);
      check_eq("rst_wdata", wd[g], 32'd0);
      check_eq("mem_clk_low", 32'(mclk[g]), 32'(clk));
    end
    @(posedge clk);
    #1 check_eq("mem_clk_high", 32'(mclk[0]), 32'(clk));
    @(negedge clk);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;

    run(0, 16'd0, 16'd1000, 1'b0, 0);
    run(1, 16'd300, 16'd2000, 1'b0, 0);
    run(2, 16'd400, 16'd3000, 1'b0, 0);
    run(0, 16'd200, 16'd200, 1'b0, 0);
    run(0, 16'd0, 16'd1000, 1'b1, 0);
    run(0, 16'd0, 16'd1000, 1'b0, 9);
    run(0, 16'd0, 16'd1000, 1'b0, 0);
    run(2, 16'h2000, 16'hFFF4, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      rg = $urandom_range(0, 2);
      ra = 16'($urandom);
      rb = ra + 16'h4000 + 16'($urandom_range(0, 255));
      run(rg, ra, rb, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
